stream_mux_arb: RTL and testbench
=================================

STREAM_MUX_ARB -- requirements
Module: stream_mux_arb

Interface
REQ-001 Parameter WIDTH, default 8, meaning data bits per channel; legal range 1 or greater.
REQ-002 Parameter N, default 8, meaning number of input channels; legal range 2 to 64.
REQ-003 Derived SELW = max(1, ceil(log2(N))); it is not a user parameter.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high, ports named as below.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  async active-high reset.
REQ-007 in_data  in  N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 in_valid  in  N  per-channel beat valid.
REQ-009 in_last  in  N  per-channel end-of-packet marker, meaningful only with in_valid.
REQ-010 in_ready  out  N  per-channel accept.
REQ-011 mode  in  1  0 = manual select, 1 = round-robin.
REQ-012 sel  in  SELW  channel index used in manual mode.
REQ-013 out_data  out  WIDTH  registered data.
REQ-014 out_valid  out  1  registered valid.
REQ-015 out_last  out  1  registered last.
REQ-016 out_ch  out  SELW  source channel of the current out beat.
REQ-017 out_ready  in  1  downstream accept.

Function
REQ-018 The FSM SHALL have states IDLE and LOCK, plus register gch[SELW] (granted channel) and rr_ptr[SELW] (last round-robin grant).
REQ-019 In IDLE with mode=0, the FSM SHALL grant gch=sel and go to LOCK when sel<N and in_valid[sel]=1; sel>=N grants nothing.
REQ-020 In IDLE with mode=1, the FSM SHALL grant the first k with in_valid[k]=1, scanning rr_ptr+1, rr_ptr+2, ... modulo N; it sets rr_ptr=k and goes to LOCK.
REQ-021 mode and sel SHALL be sampled only in IDLE; changes during LOCK have no effect until the next IDLE.
REQ-022 in_ready[k] SHALL be 1 only when state=LOCK, k=gch and (out_valid=0 or out_ready=1); all other in_ready bits are 0, and in_ready is 0 in IDLE.
REQ-023 Input transfer occurs when in_valid[gch] and in_ready[gch] are both 1; on that edge out_data, out_last and out_ch SHALL load in_data[gch], in_last[gch] and gch, and out_valid=1.
REQ-024 On an edge with out_valid=1, out_ready=1 and no input transfer, out_valid SHALL go to 0; output registers hold whenever out_valid=1 and out_ready=0.
REQ-025 Latency: the first beat of a packet appears on out_valid 2 cycles after in_valid rises from IDLE (1 arbitration cycle plus 1 register cycle); subsequent beats have 1 cycle latency.
REQ-026 Throughput: with out_ready held at 1, the block SHALL accept one beat per cycle within a packet.
REQ-027 An input transfer with in_last=1 SHALL return the FSM to IDLE on the same edge; the next grant occurs no earlier than the following cycle.
REQ-028 While LOCK is held, beats from non-granted channels SHALL never reach out_data, and packets never interleave.
REQ-029 rr_ptr wrap: after a grant to channel N-1, the next scan SHALL start at channel 0.
REQ-030 Simultaneous drain and fill (out_valid=1, out_ready=1 and an input transfer) SHALL replace the output registers with no bubble, and out_valid stays 1.

Reset
REQ-031 While rst=1, asynchronously: state=IDLE, gch=0, rr_ptr=N-1, out_valid=0, out_data=0, out_last=0, out_ch=0, in_ready=0.
REQ-032 Reset mid-packet SHALL discard the packet; after release the first round-robin grant goes to the lowest valid channel starting from 0.

Verification
REQ-033 Reset, then mode=1 with all 8 in_valid=1 and single-beat packets (in_last=1), out_ready=1 -> out_ch sequence is 0,1,2,...,7,0, one grant every 2 cycles.
REQ-034 mode=0, sel=5, channel 5 sends a 4-beat packet 0x11, 0x22, 0x33, 0x44 with in_last on beat 4, while channel 2 has in_valid=1 -> out_data is 0x11..0x44 with out_ch=5, and in_ready[2] stays 0 throughout.
REQ-035 out_ready=0 for 3 cycles mid-packet -> out_data holds its value, in_ready[gch]=0, no beat is lost or duplicated, and streaming resumes when out_ready=1.
REQ-036 mode=0, sel=7 with N=6 -> no grant, state stays IDLE, out_valid=0.
REQ-037 rst asserted during beat 2 of a packet -> all outputs go to 0 immediately; after release, channel 3 alone valid in mode=1 -> granted, out_ch=3.
REQ-038 mode toggled and sel changed during LOCK -> the grant is unchanged until in_last is accepted; the new mode and sel take effect at the next IDLE.

Source files
------------

// File: rtl/stream_mux_arb.sv
// N-to-1 packet stream multiplexer with manual or round-robin arbitration.
// A grant is held for a whole packet; output data path is a single register stage.
module stream_mux_arb #(
  parameter int WIDTH = 8,
  parameter int N     = 8,
  localparam int SELW = (N > 2) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  output logic                 out_last,
  output logic [SELW-1:0]      out_ch,
  input  logic                 out_ready
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [SELW-1:0]   gch;
  logic [SELW-1:0]   gch_nxt;
  logic [SELW-1:0]   rr_ptr;
  logic [SELW-1:0]   rr_nxt;
  logic [SELW-1:0]   scan_sel;
  logic              found;
  logic              can_load;
  logic              xfer;
  logic              cur_valid;
  logic              cur_last;
  logic [WIDTH-1:0]  cur_data;

  // Output register is free when empty or being drained this cycle
  assign can_load = ~out_valid | out_ready;

  // Select the granted channel's beat
  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    cur_data  = {WIDTH{1'b0}};
    for (int k = 0; k < N; k++) begin
      if (gch == SELW'(k)) begin
        cur_valid = in_valid[k];
        cur_last  = in_last[k];
        cur_data  = in_data[k*WIDTH +: WIDTH];
      end else begin
        cur_valid = cur_valid;
      end
    end
  end

  // Ready goes only to the locked channel, and only when the output can take a beat
  always_comb begin
    in_ready = {N{1'b0}};
    for (int k = 0; k < N; k++) begin
      if ((state == LOCK) && can_load && (gch == SELW'(k))) begin
        in_ready[k] = 1'b1;
      end else begin
        in_ready[k] = 1'b0;
      end
    end
  end

  assign xfer = (state == LOCK) && can_load && cur_valid;

  // Arbitration and packet-lock next-state logic
  always_comb begin
    state_nxt = state;
    gch_nxt   = gch;
    rr_nxt    = rr_ptr;
    found     = 1'b0;
    scan_sel  = {SELW{1'b0}};
    case (state)
      IDLE: begin
        if (mode == 1'b0) begin
          // sel values at or beyond N match no channel and so grant nothing
          for (int k = 0; k < N; k++) begin
            if ((sel == SELW'(k)) && in_valid[k]) begin
              found   = 1'b1;
              gch_nxt = SELW'(k);
            end else begin
              found = found;
            end
          end
        end else begin
          for (int i = 1; i <= N; i++) begin
            scan_sel = SELW'((int'(rr_ptr) + i) % N);
            if (!found && in_valid[scan_sel]) begin
              found   = 1'b1;
              gch_nxt = scan_sel;
              rr_nxt  = scan_sel;
            end else begin
              found = found;
            end
          end
        end
        if (found) begin
          state_nxt = LOCK;
        end else begin
          state_nxt = IDLE;
        end
      end
      LOCK: begin
        if (xfer && cur_last) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = LOCK;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Arbiter state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      gch    <= {SELW{1'b0}};
      rr_ptr <= SELW'(N - 1);
    end else begin
      state  <= state_nxt;
      gch    <= gch_nxt;
      rr_ptr <= rr_nxt;
    end
  end

  // Output register stage: load on transfer, clear valid on a pure drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= {WIDTH{1'b0}};
      out_last  <= 1'b0;
      out_ch    <= {SELW{1'b0}};
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= cur_data;
      out_last  <= cur_last;
      out_ch    <= gch;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_stream_mux_arb.sv
// Directed testbench for stream_mux_arb: an N=8 instance for the main scenarios
// and an N=6 instance for out-of-range manual select.
module tb_stream_mux_arb;

  logic        clk;
  logic        rst;
  logic [63:0] in_data;
  logic [7:0]  in_valid;
  logic [7:0]  in_last;
  logic [7:0]  in_ready;
  logic        mode;
  logic [2:0]  sel;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic [2:0]  out_ch;
  logic        out_ready;

  logic [47:0] in_data6;
  logic [5:0]  in_valid6;
  logic [5:0]  in_last6;
  logic [5:0]  in_ready6;
  logic        mode6;
  logic [2:0]  sel6;
  logic [7:0]  out_data6;
  logic        out_valid6;
  logic        out_last6;
  logic [2:0]  out_ch6;
  logic        out_ready6;

  int checks;
  int errors;

  stream_mux_arb #(.WIDTH(8), .N(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_valid(out_valid), .out_last(out_last), .out_ch(out_ch), .out_ready(out_ready)
  );

  stream_mux_arb #(.WIDTH(8), .N(6)) dut6 (
    .clk(clk), .rst(rst), .in_data(in_data6), .in_valid(in_valid6), .in_last(in_last6),
    .in_ready(in_ready6), .mode(mode6), .sel(sel6), .out_data(out_data6),
    .out_valid(out_valid6), .out_last(out_last6), .out_ch(out_ch6), .out_ready(out_ready6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input logic [7:0] v);
    in_data[k*8 +: 8] = v;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    in_data    = 64'd0;
    in_valid   = 8'd0;
    in_last    = 8'd0;
    mode       = 1'b0;
    sel        = 3'd0;
    out_ready  = 1'b1;
    in_data6   = 48'd0;
    in_valid6  = 6'h3F;
    in_last6   = 6'h3F;
    mode6      = 1'b0;
    sel6       = 3'd7;
    out_ready6 = 1'b1;
    in_data6[5*8 +: 8] = 8'h55;

    // Reset state
    #2;
    check("rst_out_valid", out_valid, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_last", out_last, 64'd0);
    check("rst_out_ch", out_ch, 64'd0);
    check("rst_in_ready", in_ready, 64'd0);
    step();
    step();
    rst = 1'b0;

    // Round-robin over all channels, single-beat packets, wrap 7 -> 0
    mode     = 1'b1;
    in_valid = 8'hFF;
    in_last  = 8'hFF;
    for (int k = 0; k < 8; k++) set_ch(k, 8'hA0 + 8'(k));
    for (int i = 0; i < 9; i++) begin
      step();
      check("rr_grant_ready", in_ready, 64'd1 << (i % 8));
      check("rr_gap_valid", out_valid, 64'd0);
      check("n6_sel7_valid", out_valid6, 64'd0);
      check("n6_sel7_ready", in_ready6, 64'd0);
      step();
      check("rr_out_valid", out_valid, 64'd1);
      check("rr_out_ch", out_ch, 64'(i % 8));
      check("rr_out_data", out_data, 64'(8'hA0 + 8'(i % 8)));
      check("rr_out_last", out_last, 64'd1);
    end
    in_valid = 8'd0;
    in_last  = 8'd0;
    step();
    check("rr_drain_valid", out_valid, 64'd0);

    // Manual select in range on the N=6 instance still grants
    sel6 = 3'd5;
    step();
    check("n6_sel5_ready", in_ready6, 64'h20);
    step();
    check("n6_sel5_valid", out_valid6, 64'd1);
    check("n6_sel5_ch", out_ch6, 64'd5);
    check("n6_sel5_data", out_data6, 64'h55);
    in_valid6 = 6'd0;

    // Manual sel=5, 4-beat packet while channel 2 also requests
    mode     = 1'b0;
    sel      = 3'd5;
    in_valid = 8'h24;
    in_last  = 8'h00;
    set_ch(5, 8'h11);
    set_ch(2, 8'hEE);
    step();
    check("man_grant_ready", in_ready, 64'h20);
    for (int b = 0; b < 4; b++) begin
      step();
      check("man_out_data", out_data, 64'(8'h11 * 8'(b + 1)));
      check("man_out_ch", out_ch, 64'd5);
      check("man_out_last", out_last, (b == 3) ? 64'd1 : 64'd0);
      check("man_ch2_ready", in_ready[2], 64'd0);
      if (b < 3) begin
        set_ch(5, 8'h11 * 8'(b + 2));
        in_last = (b == 2) ? 8'h20 : 8'h00;
      end else begin
        in_valid = 8'h04;
        in_last  = 8'h00;
      end
    end
    step();
    check("man_idle_valid", out_valid, 64'd0);
    check("man_idle_ch2_ready", in_ready[2], 64'd0);
    in_valid = 8'd0;

    // Backpressure: out_ready low for 3 cycles mid-packet on channel 6
    mode     = 1'b1;
    in_valid = 8'h40;
    set_ch(6, 8'h61);
    step();
    check("bp_grant_ready", in_ready, 64'h40);
    step();
    check("bp_beat1", out_data, 64'h61);
    set_ch(6, 8'h62);
    out_ready = 1'b0;
    #1;
    check("bp_ready_low", in_ready, 64'd0);
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp_hold_data", out_data, 64'h61);
      check("bp_hold_valid", out_valid, 64'd1);
      check("bp_hold_ready", in_ready, 64'd0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_resume_ready", in_ready, 64'h40);
    step();
    check("bp_beat2", out_data, 64'h62);
    check("bp_beat2_valid", out_valid, 64'd1);
    set_ch(6, 8'h63);
    in_last = 8'h40;
    step();
    check("bp_beat3", out_data, 64'h63);
    check("bp_beat3_last", out_last, 64'd1);
    in_valid = 8'd0;
    in_last  = 8'd0;
    step();
    check("bp_drain_valid", out_valid, 64'd0);

    // mode/sel changes during LOCK take effect only at the next IDLE
    mode     = 1'b0;
    sel      = 3'd1;
    in_valid = 8'h0B;
    set_ch(0, 8'hC0);
    set_ch(1, 8'hB1);
    set_ch(3, 8'hD3);
    step();
    check("lk_grant_ready", in_ready, 64'h02);
    mode = 1'b1;
    sel  = 3'd3;
    step();
    check("lk_beat1_ch", out_ch, 64'd1);
    check("lk_beat1_data", out_data, 64'hB1);
    check("lk_still_ready", in_ready, 64'h02);
    set_ch(1, 8'hB2);
    in_last = 8'h03;
    step();
    check("lk_beat2_data", out_data, 64'hB2);
    check("lk_beat2_ch", out_ch, 64'd1);
    check("lk_beat2_last", out_last, 64'd1);
    check("lk_idle_ready", in_ready, 64'd0);
    step();
    check("lk_new_mode_ready", in_ready, 64'h01);
    check("lk_new_mode_valid", out_valid, 64'd0);
    step();
    check("lk_new_ch", out_ch, 64'd0);
    check("lk_new_data", out_data, 64'hC0);
    in_valid = 8'd0;
    in_last  = 8'd0;
    step();

    // Reset during beat 2, then channel 3 alone in round-robin
    mode     = 1'b1;
    in_valid = 8'h10;
    set_ch(4, 8'h41);
    step();
    step();
    check("rs_beat1", out_data, 64'h41);
    set_ch(4, 8'h42);
    rst = 1'b1;
    #1;
    check("rs_valid", out_valid, 64'd0);
    check("rs_data", out_data, 64'd0);
    check("rs_ch", out_ch, 64'd0);
    check("rs_last", out_last, 64'd0);
    check("rs_ready", in_ready, 64'd0);
    step();
    rst      = 1'b0;
    in_valid = 8'h08;
    in_last  = 8'h08;
    set_ch(3, 8'h33);
    step();
    check("rs_grant_ready", in_ready, 64'h08);
    step();
    check("rs_out_ch", out_ch, 64'd3);
    check("rs_out_data", out_data, 64'h33);
    check("rs_out_valid", out_valid, 64'd1);
    in_valid = 8'd0;
    in_last  = 8'd0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
